// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU requests in a small FIFO, drives registered operands to a
// combinational ALU, waits one settle cycle, then returns the 64-bit result with its tag.
// Optional build macro: SEL_CHECK_EN rejects selects above MAX_SEL without touching the ALU
// and answers with rsp_result=0, rsp_err=1.
module alu_issue_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_SEL = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SEL_W-1:0]    alu_sel,
  input  logic [2*DATA_W-1:0] alu_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("DEPTH must be a power of two >= 2");
  end
  if (MAX_SEL >= 2**SEL_W) begin : gen_max_sel_check
    $error("MAX_SEL does not fit in SEL_W bits");
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] fifo_a_q   [DEPTH];
  logic [DATA_W-1:0] fifo_b_q   [DEPTH];
  logic [SEL_W-1:0]  fifo_sel_q [DEPTH];
  logic [TAG_W-1:0]  fifo_tag_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [SEL_W-1:0]    alu_sel_q;
  logic [TAG_W-1:0]    tag_q;
  logic [2*DATA_W-1:0] rsp_result_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic                rsp_err_q;

  logic push, pop, fifo_empty;
  logic load_alu, load_err, capture;
  logic head_illegal;

  logic [DATA_W-1:0] head_a, head_b;
  logic [SEL_W-1:0]  head_sel;
  logic [TAG_W-1:0]  head_tag;

  assign fifo_empty = (count_q == '0);
  assign req_ready  = (count_q != CNT_W'(DEPTH));
  assign push       = req_valid && req_ready;

  assign head_a   = fifo_a_q[rptr_q];
  assign head_b   = fifo_b_q[rptr_q];
  assign head_sel = fifo_sel_q[rptr_q];
  assign head_tag = fifo_tag_q[rptr_q];

`ifdef SEL_CHECK_EN
  assign head_illegal = (head_sel > SEL_W'(MAX_SEL));
`else
  assign head_illegal = 1'b0;
`endif

  // FIFO storage: data needs no reset, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wptr_q]   <= req_a;
      fifo_b_q[wptr_q]   <= req_b;
      fifo_sel_q[wptr_q] <= req_sel;
      fifo_tag_q[wptr_q] <= req_tag;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; a pop either issues to the ALU or, for an
  // illegal select, answers directly with an error response.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_alu = 1'b0;
    load_err = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            load_err = 1'b1;
            state_d  = StResp;
          end else begin
            load_alu = 1'b1;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_illegal) begin
              load_err = 1'b1;
              state_d  = StResp;
            end else begin
              load_alu = 1'b1;
              state_d  = StExec;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU operand registers and response capture; ALU registers only change on a legal pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (load_alu) begin
        alu_a_q   <= head_a;
        alu_b_q   <= head_b;
        alu_sel_q <= head_sel;
        tag_q     <= head_tag;
      end
      if (capture) begin
        rsp_result_q <= alu_out;
        rsp_tag_q    <= tag_q;
        rsp_err_q    <= 1'b0;
      end else if (load_err) begin
        rsp_result_q <= '0;
        rsp_tag_q    <= head_tag;
        rsp_err_q    <= 1'b1;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = !fifo_empty || (state_q != StIdle);

endmodule
